mux4to1_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 4:1 single-bit mux channel. Four requesters compete for the channel. The block issues a registered one-hot grant and the matching 2-bit select. It gates the muxed data bit onto q while a grant is active. A grant tenure is bounded so that no requester can starve the others.

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 26 ++
 rtl/mux4to1_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux4to1_rr_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4:1 mux round-robin arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Encode a one-hot (or zero) vector into its index; zero maps to 0.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit after start_ptr, wrapping.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic [SEL_W-1:0]   start_ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = SEL_W'(start_ptr + SEL_W'(i));
      if (!found && req_mask[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4to1_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 single-bit mux with bounded grant tenure.
// Define MUX4_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module mux4to1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] d,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               valid,
  output logic               q
);

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [SEL_W-1:0]   select_n;
  logic               valid_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [SEL_W-1:0]   last_ptr, last_n;

  logic [NUM_REQ-1:0] pick_mask;
  logic [SEL_W-1:0]   start_ptr;
  logic [SEL_W-1:0]   winner;
  logic               found;
  logic [SEL_W-1:0]   holder;
  logic               hold_done;

`ifdef MUX4_ARB_FIXED_PRIO_EN
  // Searching from 3 makes requester 0 the first candidate every time.
  assign start_ptr = SEL_W'(3);
`else
  assign start_ptr = last_ptr;
`endif

  // In BUSY only requesters other than the holder compete.
  assign pick_mask = (state == IDLE) ? req : (req & ~grant);
  assign holder    = onehot_to_idx(grant);
  assign hold_done = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  rr_pick u_rr_pick (
    .req_mask  (pick_mask),
    .start_ptr (start_ptr),
    .winner    (winner),
    .found     (found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      select   <= '0;
      valid    <= 1'b0;
      hold_cnt <= '0;
      last_ptr <= SEL_W'(3);
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      select   <= select_n;
      valid    <= valid_n;
      hold_cnt <= hold_n;
      last_ptr <= last_n;
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    select_n = select;
    valid_n  = valid;
    hold_n   = hold_cnt;
    last_n   = last_ptr;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_n  = BUSY;
          grant_n  = NUM_REQ'(1) << winner;
          select_n = winner;
          valid_n  = 1'b1;
          hold_n   = '0;
          last_n   = winner;
        end
      end
      BUSY: begin
        if (!req[holder] || hold_done) begin
          if (found) begin
            grant_n  = NUM_REQ'(1) << winner;
            select_n = winner;
            valid_n  = 1'b1;
            hold_n   = '0;
            last_n   = winner;
          end else if (!req[holder]) begin
            // Nobody left: go idle, select keeps its last value.
            state_n = IDLE;
            grant_n = '0;
            valid_n = 1'b0;
            hold_n  = '0;
          end else begin
            hold_n = '0;
          end
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
        hold_n  = '0;
      end
    endcase
  end

  // Data bit is gated by the registered grant so q is 0 while idle.
  assign q = valid & d[select];

endmodule

// File: tb/tb_mux4to1_rr_arbiter.sv
// Scoreboard bench for mux4to1_rr_arbiter (MAX_HOLD=4); stimulus pushes expectations, monitor checks.
module tb_mux4to1_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] grant;
  logic [1:0] select;
  logic       valid;
  logic       q;

  int checks   = 0;
  int failures = 0;
  int step_id  = 0;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       q;
    int         id;
  } exp_t;

  exp_t sb[$];
  logic [1:0] last_exp_sel;

  mux4to1_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .d      (d),
    .grant  (grant),
    .select (select),
    .valid  (valid),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s id=%0d got=%b exp=%b", nm, id, got, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Drive inputs at a falling edge, queue the outputs expected after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] dd, input logic [3:0] eg, input logic eq);
    exp_t e;
    req = r;
    d   = dd;
    if (eg != 4'b0000) last_exp_sel = idx_of(eg);
    e.grant = eg;
    e.sel   = last_exp_sel;
    e.valid = (eg != 4'b0000);
    e.q     = eq;
    e.id    = step_id;
    step_id++;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare every presented output cycle against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant",  e.id, grant,          e.grant);
      chk("select", e.id, {2'b00, select}, {2'b00, e.sel});
      chk("valid",  e.id, {3'b000, valid}, {3'b000, e.valid});
      chk("q",      e.id, {3'b000, q},     {3'b000, e.q});
    end
  end

  initial begin
    int wait_cyc;
    rst_n = 1'b0;
    req   = 4'b0000;
    d     = 4'b0000;
    last_exp_sel = 2'd0;

    // Reset state
    #2;
    chk("rst_grant",  -1, grant,           4'b0000);
    chk("rst_select", -1, {2'b00, select}, 4'b0000);
    chk("rst_valid",  -1, {3'b000, valid}, 4'b0000);
    chk("rst_q",      -1, {3'b000, q},     4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request then drop: requester 0 wins first after reset
    step(4'b0001, 4'b0001, 4'b0001, 1'b1);
    step(4'b0000, 4'b0001, 4'b0000, 1'b0);

    // 0 and 2 held: last_ptr=0 so 2 wins first; tenures of 4 with no bubble
    for (int i = 0; i < 4; i++) step(4'b0101, 4'b0100, 4'b0100, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0101, 4'b0100, 4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0101, 4'b0100, 4'b0100, 1'b1);
    step(4'b0000, 4'b0100, 4'b0000, 1'b0);

    // All requesting, each holder drops after one cycle (last_ptr=2)
    step(4'b1111, 4'b1010, 4'b1000, 1'b1);
    step(4'b0111, 4'b1010, 4'b0001, 1'b0);
    step(4'b1110, 4'b1010, 4'b0010, 1'b1);
    step(4'b1101, 4'b1010, 4'b0100, 1'b0);
    step(4'b1011, 4'b1010, 4'b1000, 1'b1);
    step(4'b0111, 4'b1010, 4'b0001, 1'b0);
    step(4'b0000, 4'b1010, 4'b0000, 1'b0);

    // Lone requester 3 keeps the grant across hold-limit wraps; q follows d[3]
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(4'b1000, 4'b1000, 4'b1000, 1'b1);
      else            step(4'b1000, 4'b0111, 4'b1000, 1'b0);
    end
    step(4'b0000, 4'b1000, 4'b0000, 1'b0);

    // Asynchronous reset in the middle of requester 2's tenure
    step(4'b0100, 4'b0100, 4'b0100, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", -2, grant,           4'b0000);
    chk("async_valid", -2, {3'b000, valid}, 4'b0000);
    chk("async_q",     -2, {3'b000, q},     4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp_sel = 2'd0;
    step(4'b1111, 4'b0110, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0111, 4'b0110, 4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0111, 4'b0110, 4'b0010, 1'b1);
`ifdef MUX4_ARB_FIXED_PRIO_EN
    // Forced rotate away from 1 goes back to requester 0
    for (int i = 0; i < 4; i++) step(4'b0111, 4'b0110, 4'b0001, 1'b0);
`else
    // Forced rotate away from 1 continues to requester 2
    for (int i = 0; i < 4; i++) step(4'b0111, 4'b0110, 4'b0100, 1'b1);
`endif
    step(4'b0000, 4'b0110, 4'b0000, 1'b0);

    // Drain scoreboard with a bound
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain left=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
